alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, operand/result width in bits (legal range 8..64).
REQ-002 The block SHALL have parameter SH_W, default 5, shift-amount width, equal to clog2(WIDTH).
REQ-003 The block SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port start  input  1  request; sampled only while ready=1.
REQ-006 The block SHALL have port Upr_ALU  input  4  opcode, captured with start.
REQ-007 The block SHALL have ports A and B  input  WIDTH  operands, captured with start.
REQ-008 The block SHALL have port ready  output  1  high when idle and able to accept start.
REQ-009 The block SHALL have port valid  output  1  one-cycle pulse marking a new result.
REQ-010 The block SHALL have port Out_ALU  output  WIDTH  registered result, held until the next valid.
REQ-011 The block SHALL have port C  output  1  registered compare/carry flag, held until the next valid.
REQ-012 The block SHALL have port err  output  1  registered illegal-opcode flag, held until the next valid.

Function
REQ-013 Opcodes SHALL be: 0 zero; 1 A+B; 2 A-B; 3 A&B; 4 A|B; 5 compare A>B unsigned; 6 compare A==B; 7 A shifted left by B[SH_W-1:0]; 8 A*B unsigned, low WIDTH bits.
REQ-014 The FSM SHALL have states IDLE, EXEC and DONE; ready=1 only in IDLE.
REQ-015 In IDLE with start=1, the block SHALL capture A, B and Upr_ALU and go to EXEC; start=0 SHALL keep IDLE.
REQ-016 Ops 0-6 and 9-15 SHALL finish in one EXEC cycle; valid SHALL assert 2 cycles after the start edge.
REQ-017 Op 7 SHALL shift one bit per EXEC cycle for shamt cycles; shamt=0 SHALL take one EXEC cycle; latency SHALL be max(shamt,1)+1.
REQ-018 Op 8 SHALL use shift-add, one multiplier bit per cycle, for exactly WIDTH EXEC cycles; latency SHALL be WIDTH+1.
REQ-019 On leaving EXEC the block SHALL load Out_ALU, C and err, and enter DONE with valid=1 for exactly one cycle; DONE SHALL return to IDLE on the next edge.
REQ-020 For op 1, C SHALL be the carry-out; for op 2, C SHALL be the borrow (1 when A<B unsigned); sums SHALL wrap modulo 2^WIDTH.
REQ-021 For ops 5/6, Out_ALU SHALL be 0 and C SHALL be the compare result; for ops 0,3,4,7,8, C SHALL be 0.
REQ-022 Opcodes 9-15 SHALL give Out_ALU=0, C=0, err=1; legal opcodes SHALL give err=0.
REQ-023 A start asserted while ready=0 SHALL be ignored and SHALL NOT be queued; input changes after capture SHALL NOT affect the result.
REQ-024 Back-to-back operation SHALL be possible: start in the cycle ready returns high SHALL be accepted.

Reset
REQ-025 rst_n=0 SHALL immediately force state IDLE, ready=1, valid=0, Out_ALU=0, C=0, err=0, and clear internal counters/operands, including mid-operation.
REQ-026 No valid pulse SHALL appear for an operation aborted by reset; the first start after rst_n rises SHALL behave normally.

Verification
REQ-027 WIDTH=32: start op1 A=FFFFFFFF B=00000001 -> valid 2 cycles later, Out_ALU=0, C=1, err=0.
REQ-028 op2 A=3 B=5 -> Out_ALU=FFFFFFFE, C=1; op5 A=5 B=3 -> C=1, Out_ALU=0; op6 A=B=1234 -> C=1.
REQ-029 op7 A=1 B=31 -> valid after 32 cycles, Out_ALU=80000000; B=0 -> valid after 2 cycles, Out_ALU=1.
REQ-030 op8 A=FFFF B=FFFF -> valid after 33 cycles, Out_ALU=FFFE0001; start pulses during EXEC are ignored and ready stays 0.
REQ-031 op8 started, rst_n low at cycle 10 -> outputs zero at once, ready=1, no valid; next op3 A=F0 B=3C -> Out_ALU=30.
REQ-032 op12 -> Out_ALU=0, C=0, err=1 after 2 cycles; WIDTH=8 rerun of op8 A=FF B=FF -> Out_ALU=01 after 9 cycles.

Source files
------------

// File: rtl/alu_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : alu_seq                                                         |
// | Brief    : Sequential ALU; bit-serial shift-left and shift-add multiply.   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int SH_W  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       Upr_ALU,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] Out_ALU,
    output logic             C,
    output logic             err
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_exec = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    localparam logic [3:0] c_op_zero = 4'd0;
    localparam logic [3:0] c_op_add  = 4'd1;
    localparam logic [3:0] c_op_sub  = 4'd2;
    localparam logic [3:0] c_op_and  = 4'd3;
    localparam logic [3:0] c_op_or   = 4'd4;
    localparam logic [3:0] c_op_gt   = 4'd5;
    localparam logic [3:0] c_op_eq   = 4'd6;
    localparam logic [3:0] c_op_shl  = 4'd7;
    localparam logic [3:0] c_op_mul  = 4'd8;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic [3:0]       r_op;
    logic [SH_W-1:0]  r_cnt;

    logic             w_last;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [SH_W-1:0]  w_shamt;
    logic [SH_W-1:0]  w_cap_shamt;
    logic [WIDTH-1:0] w_shl;
    logic [WIDTH-1:0] w_mul_acc;
    logic [WIDTH-1:0] w_res;
    logic             w_c;
    logic             w_err;
    logic [SH_W-1:0]  w_cnt_init;

    assign ready = (r_state == c_st_idle);
    assign valid = (r_state == c_st_done);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: if (start) w_state_nxt = c_st_exec;
            c_st_exec: if (w_last) w_state_nxt = c_st_done;
            c_st_done: w_state_nxt = c_st_idle;
            default:   w_state_nxt = c_st_idle;
        endcase
    end

    // r_cnt holds the number of EXEC cycles still to run after the current one
    assign w_last      = (r_cnt == '0);
    assign w_sum       = {1'b0, r_a} + {1'b0, r_b};
    assign w_diff      = {1'b0, r_a} - {1'b0, r_b};
    assign w_shamt     = r_b[SH_W-1:0];
    assign w_cap_shamt = B[SH_W-1:0];
    assign w_shl       = (w_shamt != '0) ? (r_a << 1) : r_a;
    assign w_mul_acc   = r_acc + (r_b[0] ? r_a : '0);

    always_comb begin
        w_cnt_init = '0;
        if (Upr_ALU == c_op_shl && w_cap_shamt != '0) begin
            w_cnt_init = w_cap_shamt - SH_W'(1);
        end else if (Upr_ALU == c_op_mul) begin
            w_cnt_init = SH_W'(WIDTH - 1);
        end
    end

    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_err = 1'b0;
        case (r_op)
            c_op_zero: w_res = '0;
            c_op_add:  begin w_res = w_sum[WIDTH-1:0];  w_c = w_sum[WIDTH];  end
            c_op_sub:  begin w_res = w_diff[WIDTH-1:0]; w_c = w_diff[WIDTH]; end
            c_op_and:  w_res = r_a & r_b;
            c_op_or:   w_res = r_a | r_b;
            c_op_gt:   w_c = (r_a > r_b);
            c_op_eq:   w_c = (r_a == r_b);
            c_op_shl:  w_res = w_shl;
            c_op_mul:  w_res = w_mul_acc;
            default:   w_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_op    <= '0;
            r_cnt   <= '0;
            Out_ALU <= '0;
            C       <= 1'b0;
            err     <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_a   <= A;
                        r_b   <= B;
                        r_op  <= Upr_ALU;
                        r_acc <= '0;
                        r_cnt <= w_cnt_init;
                    end
                end
                c_st_exec: begin
                    if (r_op == c_op_shl) begin
                        r_a <= w_shl;
                    end
                    if (r_op == c_op_mul) begin
                        r_acc <= w_mul_acc;
                        r_a   <= r_a << 1;
                        r_b   <= r_b >> 1;
                    end
                    if (w_last) begin
                        Out_ALU <= w_res;
                        C       <= w_c;
                        err     <= w_err;
                    end else begin
                        r_cnt <= r_cnt - SH_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_alu_seq                                                      |
// | Brief    : Directed self-checking bench for alu_seq (WIDTH 32 and 8).      |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        ready;
    logic        valid;
    logic [31:0] out_alu;
    logic        c;
    logic        err;

    logic        s8_start;
    logic [3:0]  s8_op;
    logic [7:0]  s8_a;
    logic [7:0]  s8_b;
    logic        s8_ready;
    logic        s8_valid;
    logic [7:0]  s8_out;
    logic        s8_c;
    logic        s8_err;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(32), .SH_W(5)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .Upr_ALU(op), .A(a), .B(b),
        .ready(ready), .valid(valid), .Out_ALU(out_alu), .C(c), .err(err)
    );

    alu_seq #(.WIDTH(8), .SH_W(3)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(s8_start), .Upr_ALU(s8_op), .A(s8_a), .B(s8_b),
        .ready(s8_ready), .valid(s8_valid), .Out_ALU(s8_out), .C(s8_c), .err(s8_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Issue one op on the 32-bit instance; returns in the IDLE cycle after DONE
    task automatic do_op(input string tag, input logic [3:0] opc, input logic [31:0] av,
                         input logic [31:0] bv, input logic [31:0] e_out, input logic e_c,
                         input logic e_err, input int e_lat, input bit poke);
        int lat;
        int seen;
        @(negedge clk);
        start = 1'b1; op = opc; a = av; b = bv;
        @(posedge clk); #1;
        start = 1'b0; a = $urandom; b = $urandom; op = 4'($urandom);
        lat = 1;
        while (!valid && lat < 100) begin
            if (poke && lat == 5) begin
                start = 1'b1;
                check({tag, "_busy_rdy"}, 64'(ready), 64'd0);
            end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        check({tag, "_lat"}, 64'(lat), 64'(e_lat));
        check({tag, "_out"}, 64'(out_alu), 64'(e_out));
        check({tag, "_c"},   64'(c), 64'(e_c));
        check({tag, "_err"}, 64'(err), 64'(e_err));
        @(posedge clk); #1;
        check({tag, "_pulse"}, {62'd0, valid, ready}, 64'd1);
        if (poke) begin
            seen = 0;
            repeat (3) begin
                @(posedge clk); #1;
                if (valid) seen++;
            end
            check({tag, "_noqueue"}, 64'(seen), 64'd0);
        end
    endtask

    initial begin
        int lat;
        int seen;
        rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
        s8_start = 1'b0; s8_op = '0; s8_a = '0; s8_b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", {59'd0, ready, valid, c, err, |out_alu}, 64'h10);
        check("rst_state8", {59'd0, s8_ready, s8_valid, s8_c, s8_err, |s8_out}, 64'h10);
        @(negedge clk); rst_n = 1'b1;

        do_op("add_carry", 4'd1, 32'hFFFF_FFFF, 32'h1,        32'h0,         1'b1, 1'b0, 2,  0);
        do_op("add",       4'd1, 32'h2,         32'h3,        32'h5,         1'b0, 1'b0, 2,  0);
        do_op("sub_borrow",4'd2, 32'h3,         32'h5,        32'hFFFF_FFFE, 1'b1, 1'b0, 2,  0);
        do_op("sub",       4'd2, 32'h5,         32'h3,        32'h2,         1'b0, 1'b0, 2,  0);
        do_op("gt_true",   4'd5, 32'h5,         32'h3,        32'h0,         1'b1, 1'b0, 2,  0);
        do_op("gt_false",  4'd5, 32'h3,         32'h5,        32'h0,         1'b0, 1'b0, 2,  0);
        do_op("eq_true",   4'd6, 32'h1234,      32'h1234,     32'h0,         1'b1, 1'b0, 2,  0);
        do_op("eq_false",  4'd6, 32'h1234,      32'h1235,     32'h0,         1'b0, 1'b0, 2,  0);
        do_op("zero",      4'd0, 32'hDEAD_BEEF, 32'h1,        32'h0,         1'b0, 1'b0, 2,  0);
        do_op("or",        4'd4, 32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F, 1'b0, 1'b0, 2,  0);
        do_op("shl31",     4'd7, 32'h1,         32'd31,       32'h8000_0000, 1'b0, 1'b0, 32, 0);
        do_op("shl0",      4'd7, 32'h1,         32'd0,        32'h1,         1'b0, 1'b0, 2,  0);
        do_op("shl_wrap",  4'd7, 32'h8000_0001, 32'h21,       32'h2,         1'b0, 1'b0, 2,  0);
        do_op("mul",       4'd8, 32'hFFFF,      32'hFFFF,     32'hFFFE_0001, 1'b0, 1'b0, 33, 1);
        do_op("mul_wrap",  4'd8, 32'hFFFF_FFFF, 32'h2,        32'hFFFF_FFFE, 1'b0, 1'b0, 33, 0);
        do_op("illegal12", 4'd12, 32'h5,        32'h7,        32'h0,         1'b0, 1'b1, 2,  0);
        do_op("illegal15", 4'd15, 32'h5,        32'h7,        32'h0,         1'b0, 1'b1, 2,  0);
        do_op("pre_rst",   4'd2, 32'h3,         32'h5,        32'hFFFF_FFFE, 1'b1, 1'b0, 2,  0);

        // Abort a multiply mid-flight with an asynchronous reset
        @(negedge clk);
        start = 1'b1; op = 4'd8; a = 32'hFFFF; b = 32'hFFFF;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #3; rst_n = 1'b0; #1;
        check("abort_out", {30'd0, c, err, out_alu}, 64'd0);
        check("abort_hs", {62'd0, ready, valid}, 64'h2);
        @(negedge clk); rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (valid) seen++;
        end
        check("abort_novalid", 64'(seen), 64'd0);
        do_op("after_rst_and", 4'd3, 32'hF0, 32'h3C, 32'h30, 1'b0, 1'b0, 2, 0);

        @(negedge clk);
        s8_start = 1'b1; s8_op = 4'd8; s8_a = 8'hFF; s8_b = 8'hFF;
        @(posedge clk); #1;
        s8_start = 1'b0; s8_a = 8'h00; s8_b = 8'h00;
        lat = 1;
        while (!s8_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check("w8_mul_lat", 64'(lat), 64'd9);
        check("w8_mul_out", 64'(s8_out), 64'h01);
        check("w8_mul_flags", {62'd0, s8_c, s8_err}, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
